countdown_timer: RTL and testbench



---
 rtl/countdown_timer_pkg.sv | 5 +
 rtl/countdown_timer.sv | 45 ++++
 tb/tb_countdown_timer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: state encodings and default width shared by the counter family
package countdown_timer_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-cycle terminal pulse and optional auto-reload
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st,
  input  logic [WIDTH-1:0] X,
  input  logic             en,
  input  logic             reload,
  output logic [WIDTH-1:0] o,
  output logic             busy,
  output logic             done
);
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_o, r_ld, w_o_nx, w_ld_nx;
  logic             r_done, w_done_nx, w_adv, w_term;
  always_comb begin
    w_adv      = !st && (r_state == RUN) && en;
    // o<=1 rather than o==1 so a zero count can never be decremented
    w_term     = w_adv && (r_o <= WIDTH'(1));
    w_state_nx = st ? ((X == '0) ? IDLE : RUN) : (w_term && !reload) ? IDLE : r_state;
    w_o_nx     = st ? X : w_term ? (reload ? r_ld : '0) : w_adv ? r_o - WIDTH'(1) : r_o;
    w_ld_nx    = st ? X : r_ld;
    w_done_nx  = st ? (X == '0) : w_term;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_o     <= '0;
      r_ld    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_o     <= w_o_nx;
      r_ld    <= w_ld_nx;
      r_done  <= w_done_nx;
    end
  end
  assign o    = r_o;
  assign done = r_done;
  assign busy = (r_state == RUN);
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: vector table, directed corner sequences and random stimulus vs a behavioural model
module tb_countdown_timer;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b0, st = 1'b0, en = 1'b0, reload = 1'b0;
  logic [W-1:0] X = '0;
  logic [W-1:0] o;
  logic         busy, done;
  int n_cmp = 0, n_bad = 0;
  int m_o = 0, m_ld = 0;
  bit m_run = 1'b0, m_done = 1'b0;
  typedef struct {bit s; int x; bit e; bit r; int eo; bit eb; bit ed;} vec_t;
  vec_t vt[17];

  countdown_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .st(st), .X(X), .en(en), .reload(reload),
    .o(o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string nm);
    cmp({nm, ".o"}, 32'(o), 32'(m_o));
    cmp({nm, ".busy"}, 32'(busy), 32'(m_run));
    cmp({nm, ".done"}, 32'(done), 32'(m_done));
  endtask

  // Model: remaining count, reload value and running flag, advanced per rising edge
  task automatic model_edge(input bit s, input int x, input bit e, input bit r);
    m_done = 1'b0;
    if (s) begin
      m_ld = x; m_o = x; m_run = (x != 0); m_done = (x == 0);
    end else if (m_run && e) begin
      m_o = m_o - 1;
      if (m_o == 0) begin
        m_done = 1'b1;
        if (r) m_o = m_ld;
        else m_run = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_o = 0; m_ld = 0; m_run = 1'b0; m_done = 1'b0;
  endtask

  task automatic step(input bit s, input int x, input bit e, input bit r, input string nm);
    st = s; X = x[W-1:0]; en = e; reload = r;
    @(posedge clk);
    model_edge(s, x, e, r);
    #1;
    check_model(nm);
  endtask

  initial begin
    int pulses;
    //             st  X  en rl  o  busy done
    vt[0]  = '{1, 3, 0, 0, 3, 1, 0};
    vt[1]  = '{0, 0, 1, 0, 2, 1, 0};
    vt[2]  = '{0, 0, 1, 0, 1, 1, 0};
    vt[3]  = '{0, 0, 1, 0, 0, 0, 1};
    vt[4]  = '{0, 0, 1, 1, 0, 0, 0};
    vt[5]  = '{1, 0, 1, 0, 0, 0, 1};
    vt[6]  = '{0, 0, 1, 0, 0, 0, 0};
    vt[7]  = '{1, 2, 0, 1, 2, 1, 0};
    vt[8]  = '{0, 0, 1, 1, 1, 1, 0};
    vt[9]  = '{0, 0, 1, 1, 2, 1, 1};
    vt[10] = '{0, 0, 0, 1, 2, 1, 0};
    vt[11] = '{0, 0, 1, 1, 1, 1, 0};
    vt[12] = '{0, 0, 1, 0, 0, 0, 1};
    vt[13] = '{1, 1, 0, 1, 1, 1, 0};
    vt[14] = '{0, 0, 1, 1, 1, 1, 1};
    vt[15] = '{0, 0, 1, 1, 1, 1, 1};
    vt[16] = '{1, 5, 1, 1, 5, 1, 0};

    #2;
    cmp("rst.o", 32'(o), 0);
    cmp("rst.busy", 32'(busy), 0);
    cmp("rst.done", 32'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    foreach (vt[i]) begin
      step(vt[i].s, vt[i].x, vt[i].e, vt[i].r, $sformatf("vec%0d", i));
      cmp($sformatf("tbl%0d.o", i), 32'(o), 32'(vt[i].eo));
      cmp($sformatf("tbl%0d.busy", i), 32'(busy), 32'(vt[i].eb));
      cmp($sformatf("tbl%0d.done", i), 32'(done), 32'(vt[i].ed));
    end

    // async reset mid-count, no clock edge involved
    #2;
    rst_n = 1'b0;
    #1;
    cmp("arst.o", 32'(o), 0);
    cmp("arst.busy", 32'(busy), 0);
    cmp("arst.done", 32'(done), 0);
    model_reset();
    #1 rst_n = 1'b1;
    step(0, 0, 1, 0, "post_rst");

    step(1, 30, 0, 0, "cd30_load");
    for (int i = 0; i < 36; i++) step(0, 0, 1, 0, "cd30");
    cmp("cd30.end_o", 32'(o), 0);

    step(1, 10, 1, 0, "pause_load");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "pause_run");
    cmp("pause.o7", 32'(o), 7);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, "pause_hold");
    cmp("pause.hold", 32'(o), 7);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, "pause_resume");
    cmp("pause.done", 32'(done), 1);

    step(1, 4, 1, 1, "rl_load");
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 1, "rl_run");
      pulses += int'(done);
    end
    cmp("rl.pulses", 32'(pulses), 3);
    cmp("rl.busy", 32'(busy), 1);

    step(1, 255, 1, 0, "cd255_load");
    for (int i = 0; i < 258; i++) step(0, 0, 1, 0, "cd255");
    cmp("cd255.o", 32'(o), 0);

    step(1, 20, 1, 0, "rs_load");
    for (int i = 0; i < 19; i++) step(0, 0, 1, 0, "rs_run");
    cmp("rs.o1", 32'(o), 1);
    step(1, 9, 1, 0, "rs_restart");
    cmp("rs.o9", 32'(o), 9);
    cmp("rs.nodone", 32'(done), 0);
    cmp("rs.busy", 32'(busy), 1);

    for (int i = 0; i < 3000; i++) begin
      bit s, e, r;
      int x;
      s = ($urandom_range(0, 15) == 0);
      x = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      e = ($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 1));
      step(s, x, e, r, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
